// File: rtl/pc_stack_unit.sv
// Program counter with shared subroutine/interrupt return stack and interrupt-enable flag.
// Define PC_STACK_CIRCULAR_EN to make a push-while-full overwrite the oldest entry.
module pc_stack_unit #(
    parameter int unsigned      ADDR_W       = 12,
    parameter int unsigned      DEPTH        = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 12'h000,
    parameter logic [ADDR_W-1:0] INT_VECTOR   = 12'h004
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pc_en_i,
    input  logic [3:0]                 pc_oper_i,
    input  logic                       jsb_i,
    input  logic                       ret_i,
    input  logic                       int_i,
    input  logic                       reti_i,
    input  logic [ADDR_W-1:0]          target_i,
    input  logic [ADDR_W-1:0]          offset_i,
    input  logic                       flag_z_i,
    input  logic                       flag_c_i,
    output logic [ADDR_W-1:0]          pc_o,
    output logic                       int_en_o,
    output logic [$clog2(DEPTH+1)-1:0] stk_depth_o,
    output logic                       stk_ovf_o,
    output logic                       stk_unf_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned DEP_W = $clog2(DEPTH + 1);

`ifdef PC_STACK_CIRCULAR_EN
    localparam bit CIRCULAR = 1'b1;
`else
    localparam bit CIRCULAR = 1'b0;
`endif

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  sp;          // next free slot; top entry is sp-1
    logic [ADDR_W-1:0] top_entry;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_rel;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] push_val;
    logic              int_en_nxt;
    logic              do_push;
    logic              do_pop;
    logic              stk_full;
    logic              stk_empty;

    assign top_entry = mem[sp - PTR_W'(1)];
    assign pc_inc    = pc_o + ADDR_W'(1);
    assign pc_rel    = pc_o + offset_i;
    assign stk_full  = (stk_depth_o == DEP_W'(DEPTH));
    assign stk_empty = (stk_depth_o == '0);

    // Select the single winning action and the resulting PC.
    always_comb begin
        do_push    = 1'b0;
        do_pop     = 1'b0;
        push_val   = pc_inc;
        pc_nxt     = pc_o;
        int_en_nxt = int_en_o;
        if (pc_en_i) begin
            if (int_i) begin
                do_push    = 1'b1;
                push_val   = pc_o;
                pc_nxt     = INT_VECTOR;
                int_en_nxt = 1'b0;
            end else if (reti_i || ret_i) begin
                do_pop = 1'b1;
                pc_nxt = stk_empty ? pc_inc : top_entry;
                if (reti_i) begin
                    int_en_nxt = 1'b1;
                end
            end else if (jsb_i) begin
                do_push  = 1'b1;
                push_val = pc_inc;
                pc_nxt   = target_i;
            end else begin
                case (pc_oper_i)
                    4'd1:    pc_nxt = pc_inc;
                    4'd2:    pc_nxt = target_i;
                    4'd3:    pc_nxt = pc_rel;
                    4'd4:    pc_nxt = flag_z_i  ? pc_rel : pc_inc;
                    4'd5:    pc_nxt = !flag_z_i ? pc_rel : pc_inc;
                    4'd6:    pc_nxt = flag_c_i  ? pc_rel : pc_inc;
                    4'd7:    pc_nxt = !flag_c_i ? pc_rel : pc_inc;
                    default: pc_nxt = pc_o;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_o        <= RESET_VECTOR;
            int_en_o    <= 1'b1;
            stk_depth_o <= '0;
            sp          <= '0;
            stk_ovf_o   <= 1'b0;
            stk_unf_o   <= 1'b0;
        end else begin
            pc_o     <= pc_nxt;
            int_en_o <= int_en_nxt;
            if (do_push) begin
                if (stk_full) begin
                    stk_ovf_o <= 1'b1;
                    if (CIRCULAR) begin
                        sp <= sp + PTR_W'(1);
                    end
                end else begin
                    sp          <= sp + PTR_W'(1);
                    stk_depth_o <= stk_depth_o + DEP_W'(1);
                end
            end
            if (do_pop) begin
                if (stk_empty) begin
                    stk_unf_o <= 1'b1;
                end else begin
                    sp          <= sp - PTR_W'(1);
                    stk_depth_o <= stk_depth_o - DEP_W'(1);
                end
            end
        end
    end

    // Stack storage carries no reset; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (do_push && (!stk_full || CIRCULAR)) begin
            mem[sp] <= push_val;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit with a queue-based scoreboard fed by a reference model.
module tb_pc_stack_unit;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_en_i = 1'b0;
    logic [3:0]  pc_oper_i = '0;
    logic        jsb_i = 1'b0, ret_i = 1'b0, int_i = 1'b0, reti_i = 1'b0;
    logic [11:0] target_i = '0, offset_i = '0;
    logic        flag_z_i = 1'b0, flag_c_i = 1'b0;
    logic [11:0] pc_o;
    logic        int_en_o;
    logic [3:0]  stk_depth_o;
    logic        stk_ovf_o, stk_unf_o;

    pc_stack_unit dut (
        .clk(clk), .rst(rst), .pc_en_i(pc_en_i), .pc_oper_i(pc_oper_i),
        .jsb_i(jsb_i), .ret_i(ret_i), .int_i(int_i), .reti_i(reti_i),
        .target_i(target_i), .offset_i(offset_i),
        .flag_z_i(flag_z_i), .flag_c_i(flag_c_i),
        .pc_o(pc_o), .int_en_o(int_en_o), .stk_depth_o(stk_depth_o),
        .stk_ovf_o(stk_ovf_o), .stk_unf_o(stk_unf_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] pc;
        logic        ie;
        logic [3:0]  depth;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] mstk[$];
    logic [11:0] m_pc;
    logic        m_ie, m_ovf, m_unf;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mstk.delete();
        m_pc = 12'h000; m_ie = 1'b1; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic m_push(input logic [11:0] v);
        if (mstk.size() == DEPTH) begin
            m_ovf = 1'b1;
`ifdef PC_STACK_CIRCULAR_EN
            void'(mstk.pop_front());
            mstk.push_back(v);
`endif
        end else begin
            mstk.push_back(v);
        end
    endtask

    task automatic m_pop();
        if (mstk.size() == 0) begin
            m_pc  = m_pc + 12'd1;
            m_unf = 1'b1;
        end else begin
            m_pc = mstk.pop_back();
        end
    endtask

    // Drive one cycle, predict the result, clock it and compare.
    task automatic step(input logic en, input logic [3:0] op, input logic jsb, input logic ret,
                        input logic intr, input logic reti, input logic [11:0] tgt,
                        input logic [11:0] off, input logic z, input logic c);
        logic [11:0] inc, rel;
        exp_t e, got;
        pc_en_i = en; pc_oper_i = op; jsb_i = jsb; ret_i = ret; int_i = intr; reti_i = reti;
        target_i = tgt; offset_i = off; flag_z_i = z; flag_c_i = c;
        inc = m_pc + 12'd1;
        rel = m_pc + off;
        if (en) begin
            if (intr) begin
                m_push(m_pc); m_pc = 12'h004; m_ie = 1'b0;
            end else if (reti) begin
                m_pop(); m_ie = 1'b1;
            end else if (ret) begin
                m_pop();
            end else if (jsb) begin
                m_push(inc); m_pc = tgt;
            end else begin
                case (op)
                    4'd1: m_pc = inc;
                    4'd2: m_pc = tgt;
                    4'd3: m_pc = rel;
                    4'd4: m_pc = z  ? rel : inc;
                    4'd5: m_pc = !z ? rel : inc;
                    4'd6: m_pc = c  ? rel : inc;
                    4'd7: m_pc = !c ? rel : inc;
                    default: ;
                endcase
            end
        end
        e = '{pc: m_pc, ie: m_ie, depth: 4'(mstk.size()), ovf: m_ovf, unf: m_unf};
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = '{pc: pc_o, ie: int_en_o, depth: stk_depth_o, ovf: stk_ovf_o, unf: stk_unf_o};
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("sb_state", 32'(got), 32'(e));
        end
        pc_en_i = 1'b0; jsb_i = 1'b0; ret_i = 1'b0; int_i = 1'b0; reti_i = 1'b0;
    endtask

    task automatic op(input logic [3:0] o, input logic [11:0] tgt, input logic [11:0] off,
                      input logic z, input logic c);
        step(1'b1, o, 1'b0, 1'b0, 1'b0, 1'b0, tgt, off, z, c);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_pc", 32'(pc_o), 32'h000);
        chk("reset_ie", 32'(int_en_o), 32'd1);
        chk("reset_depth", 32'(stk_depth_o), 32'd0);
        chk("reset_flags", {30'd0, stk_ovf_o, stk_unf_o}, 32'd0);

        // Increment run
        for (int i = 0; i < 5; i++) op(4'd1, 12'h000, 12'h000, 1'b0, 1'b0);
        chk("inc_pc5", 32'(pc_o), 32'h005);

        // Conditional and relative branches
        op(4'd2, 12'h010, 12'h000, 1'b0, 1'b0);
        op(4'd4, 12'h000, 12'hFFC, 1'b1, 1'b0);
        chk("bz_taken", 32'(pc_o), 32'h00C);
        op(4'd2, 12'h010, 12'h000, 1'b0, 1'b0);
        op(4'd4, 12'h000, 12'hFFC, 1'b0, 1'b0);
        chk("bz_not_taken", 32'(pc_o), 32'h011);
        op(4'd5, 12'h000, 12'h00F, 1'b0, 1'b0);
        op(4'd6, 12'h000, 12'h010, 1'b0, 1'b1);
        op(4'd7, 12'h000, 12'h010, 1'b0, 1'b1);
        op(4'd9, 12'h123, 12'h010, 1'b1, 1'b1);
        op(4'd0, 12'h123, 12'h010, 1'b1, 1'b1);
        op(4'd2, 12'hFFE, 12'h000, 1'b0, 1'b0);
        op(4'd3, 12'h000, 12'h004, 1'b0, 1'b0);
        chk("rel_wrap", 32'(pc_o), 32'h002);

        // Call then immediate return
        op(4'd2, 12'h020, 12'h000, 1'b0, 1'b0);
        step(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h100, 12'h000, 1'b0, 1'b0);
        chk("call_depth", 32'(stk_depth_o), 32'd1);
        step(1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
        chk("ret_pc", 32'(pc_o), 32'h021);

        // Interrupt beats a simultaneous call
        op(4'd2, 12'h030, 12'h000, 1'b0, 1'b0);
        step(1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 12'h100, 12'h000, 1'b0, 1'b0);
        chk("int_pc", 32'(pc_o), 32'h004);
        chk("int_ie", 32'(int_en_o), 32'd0);
        step(1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0, 1'b0);
        chk("reti_pc", 32'(pc_o), 32'h030);
        chk("reti_ie", 32'(int_en_o), 32'd1);

        // Overflow: nine calls into an eight-entry stack, then drain
        op(4'd2, 12'h000, 12'h000, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++)
            step(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h200, 12'h000, 1'b0, 1'b0);
        chk("ovf_flag", 32'(stk_ovf_o), 32'd1);
        chk("ovf_depth", 32'(stk_depth_o), 32'd8);
        for (int i = 0; i < 8; i++)
            step(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
`ifdef PC_STACK_CIRCULAR_EN
        chk("drain_last", 32'(pc_o), 32'h201);
`else
        chk("drain_last", 32'(pc_o), 32'h001);
`endif
        chk("drain_depth", 32'(stk_depth_o), 32'd0);

        // Underflow and disabled strobes
        op(4'd2, 12'h040, 12'h000, 1'b0, 1'b0);
        step(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
        chk("unf_pc", 32'(pc_o), 32'h041);
        chk("unf_flag", 32'(stk_unf_o), 32'd1);
        step(1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 12'h555, 12'h000, 1'b0, 1'b0);
        step(1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 12'h555, 12'h000, 1'b0, 1'b0);
        chk("disabled_pc", 32'(pc_o), 32'h041);

        // Asynchronous reset away from any clock edge
        step(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h300, 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_pc", 32'(pc_o), 32'h000);
        chk("async_depth", 32'(stk_depth_o), 32'd0);
        chk("async_flags", {30'd0, stk_ovf_o, stk_unf_o}, 32'd0);
        chk("async_ie", 32'(int_en_o), 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        op(4'd1, 12'h000, 12'h000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Program-counter and return-stack stage directly downstream of the control-unit FSM. Consumes the FSM's PC operation code, PC enable, subroutine push/pop and interrupt entry/return strobes. Produces the registered instruction address driven to the instruction-fetch bus. Holds a fixed-depth return stack shared by subroutine calls and interrupts, plus the global interrupt-enable flag.

## Interface
- ADDR_W, 12, instruction address width
- DEPTH, 8, return-stack entries (power of two, ≥2)
- RESET_VECTOR, 12'h000, PC value after reset
- INT_VECTOR, 12'h004, PC loaded on interrupt entry

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- pc_en_i  in  1  qualifies every action below; 0 = hold all state
- pc_oper_i  in  4  PC operation from control unit
- jsb_i  in  1  subroutine call: push, jump
- ret_i  in  1  subroutine return: pop
- int_i  in  1  interrupt entry accepted by control unit
- reti_i  in  1  return from interrupt
- target_i  in  ADDR_W  absolute target (jump/call)
- offset_i  in  ADDR_W  two's-complement relative offset
- flag_z_i  in  1  ALU zero flag
- flag_c_i  in  1  ALU carry flag
- pc_o  out  ADDR_W  registered fetch address
- int_en_o  out  1  interrupt enable
- stk_depth_o  out  $clog2(DEPTH+1)  occupied entries
- stk_ovf_o  out  1  sticky push-while-full
- stk_unf_o  out  1  sticky pop-while-empty

## Operation
- Reset: pc_o=RESET_VECTOR, int_en_o=1, stk_depth_o=0, stk_ovf_o=0, stk_unf_o=0; stack contents don't-care.
- With pc_en_i=1, exactly one action per cycle, priority int_i > reti_i > ret_i > jsb_i > pc_oper_i.
- int_i: push pc_o; pc←INT_VECTOR; int_en←0.
- reti_i: pop into pc; int_en←1.
- ret_i: pop into pc; int_en unchanged.
- jsb_i: push pc_o+1; pc←target_i.
- pc_oper_i: 0 hold; 1 pc+1; 2 pc←target_i; 3 pc+offset_i; 4 Z?pc+offset_i:pc+1; 5 !Z?…; 6 C?…; 7 !C?…; 8–15 hold.
- Arithmetic modulo 2^ADDR_W; offset sign-extended at ADDR_W, no saturation.
- Pop when empty: pc←pc+1, depth stays 0, stk_unf_o←1; int_en still set on reti.
- Push when full: see Configuration; pc still loads new target, stk_ovf_o←1.
- Sticky flags cleared only by rst.
- Strobes with pc_en_i=0 are ignored entirely.

## Timing
- Single-cycle: action sampled at rising edge with pc_en_i=1; new pc_o, depth, flags visible after that edge.
- Pop data is the registered top entry; no extra cycle.
- Consecutive push/pop cycles fully back-to-back; push then pop returns pushed value next cycle.
- rst asserted mid-operation forces reset values immediately (asynchronous), regardless of clk.
- Outputs purely registered; no combinational path input→output.

## Configuration
- PC_STACK_CIRCULAR_EN defined: stack is circular; push when full overwrites oldest entry, depth stays DEPTH, stk_ovf_o←1.
- Undefined: push when full discards the pushed value, stack unchanged, depth stays DEPTH, stk_ovf_o←1.

## Test plan
- Reset/increment: rst pulse, then 5 cycles pc_en_i=1, pc_oper_i=1 -> pc_o 000,001…005; int_en_o=1, stk_depth_o=0.
- Branches: pc_o=010, offset_i=FFC, pc_oper_i=4 with Z=1 -> 00C; with Z=0 -> 011; pc_oper_i=3 at pc FFE, offset 004 -> 002 (wrap).
- Call/return: pc_o=020, jsb_i, target_i=100 -> pc 100, depth 1; next cycle ret_i -> pc 021, depth 0.
- Interrupt priority: pc_o=030, int_i and jsb_i same cycle -> pc 004, int_en_o=0, depth 1; reti_i -> pc 030, int_en_o=1.
- Overflow: 9 jsb_i from pc 000 with target 200 -> stk_ovf_o=1, depth 8; 8 ret_i -> without macro last pop yields 001, with macro yields the 9th pushed value 201 first.
- Underflow/enable: ret_i on empty at pc 040 -> pc 041, stk_unf_o=1; ret_i with pc_en_i=0 -> no change.
